// File: rtl/rfm_cnt_ctrl.sv
// rfm_cnt_ctrl: controller for the row-activation counter CAM of the RFM tracker.
// Maps activated rows onto CAM entries through a tag table and bumps the entry
// count with a read-modify-write. On an RFM request it runs the CAM find-max,
// searches for the entry holding the max, clears it and reports its row.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   INIT     | after reset: one cycle of cam_reset, then IDLE
//   IDLE     | accept ACT (act_ready) or start an RFM (rfm_req wins)
//   ACT_RD   | cam_read_en on the mapped entry, count captured at the edge
//   ACT_WR   | write saturated count+1, alert if it reaches ALERT_TH
//   MAX      | cam_max_en for exactly 4 cycles (sub = 0..3)
//   MAX_WT   | cam_max is sampled; zero means no aggressor
//   SRCH     | search the CAM with the max value as key
//   CLR      | zero the matching entry, report its row with rfm_done
module rfm_cnt_ctrl #(
  parameter int WORD_SIZE = 16,
  parameter int ENTRY_WIDTH = 7,
  parameter int TRACK_NUM = 16,
  parameter int ROW_BITS = 16,
  parameter logic [WORD_SIZE-1:0] ALERT_TH = WORD_SIZE'(1024)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   act_valid,
  input  logic [ROW_BITS-1:0]    act_row,
  output logic                   act_ready,
  input  logic                   rfm_req,
  output logic                   rfm_done,
  output logic                   rfm_hit,
  output logic [ROW_BITS-1:0]    rfm_row,
  output logic                   alert,
  output logic                   spill,
  output logic [WORD_SIZE-1:0]   cam_wdata,
  output logic [ENTRY_WIDTH-1:0] cam_addr,
  output logic                   cam_read_en,
  output logic                   cam_write_en,
  output logic                   cam_search_en,
  output logic                   cam_reset,
  output logic                   cam_max_en,
  input  logic [WORD_SIZE-1:0]   cam_rdata,
  input  logic                   cam_match,
  input  logic [ENTRY_WIDTH-1:0] cam_match_addr,
  input  logic [WORD_SIZE-1:0]   cam_max
);

  localparam int TW = (TRACK_NUM > 1) ? $clog2(TRACK_NUM) : 1;
  localparam int PW = $clog2(TRACK_NUM + 1);
  localparam logic [PW-1:0] FULL = PW'(TRACK_NUM);

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_ACT_RD, S_ACT_WR, S_MAX, S_MAX_WT, S_SRCH, S_CLR
  } state_t;

  state_t state, nxt_state;
  logic [1:0] sub, nxt_sub;
  logic [PW-1:0] fill_ptr, nxt_fill;
  logic [TW-1:0] fill_idx;
  logic alloc;

  logic [ROW_BITS-1:0] tag_row [TRACK_NUM];
  logic [TRACK_NUM-1:0] tag_vld;

  logic hit;
  logic [ENTRY_WIDTH-1:0] hit_idx;
  logic [WORD_SIZE-1:0] inc;
  logic match_ok;
  logic [TW-1:0] msel;

  // registered output images; act_ready is additionally gated by rfm_req so
  // that a simultaneous RFM request is never shown as an accepted ACT
  logic ready_q;
  logic n_ready, n_done, n_hit, n_alert, n_spill;
  logic n_read, n_write, n_search, n_reset, n_max;
  logic [ROW_BITS-1:0] n_row;
  logic [WORD_SIZE-1:0] n_wdata;
  logic [ENTRY_WIDTH-1:0] n_addr;

  assign act_ready = ready_q & ~rfm_req;
  assign fill_idx  = fill_ptr[TW-1:0];
  assign inc       = (&cam_rdata) ? cam_rdata : cam_rdata + WORD_SIZE'(1);
  assign match_ok  = cam_match && (cam_match_addr < ENTRY_WIDTH'(TRACK_NUM));
  assign msel      = cam_match_addr[TW-1:0];

  // parallel tag compare; descending scan so the lowest matching index wins
  always_comb begin
    hit = 1'b0;
    hit_idx = '0;
    for (int i = TRACK_NUM - 1; i >= 0; i--) begin
      if (tag_vld[i] && (tag_row[i] == act_row)) begin
        hit = 1'b1;
        hit_idx = ENTRY_WIDTH'(i);
      end
    end
  end

  // next state and the output values for the cycle spent in that state
  always_comb begin
    nxt_state = state;
    nxt_sub   = sub;
    nxt_fill  = fill_ptr;
    alloc     = 1'b0;
    n_done    = 1'b0;
    n_hit     = 1'b0;
    n_row     = '0;
    n_alert   = 1'b0;
    n_spill   = 1'b0;
    n_write   = 1'b0;
    n_reset   = 1'b0;
    n_wdata   = '0;
    n_addr    = '0;
    case (state)
      S_INIT: begin
        // the first INIT cycle after reset raises cam_reset, the second leaves
        if (!cam_reset) n_reset = 1'b1;
        else nxt_state = S_IDLE;
      end
      S_IDLE: begin
        if (rfm_req) begin
          nxt_state = S_MAX;
          nxt_sub   = 2'd0;
        end else if (act_valid) begin
          if (hit) begin
            nxt_state = S_ACT_RD;
            n_addr    = hit_idx;
          end else if (fill_ptr < FULL) begin
            nxt_state = S_ACT_RD;
            n_addr    = ENTRY_WIDTH'(fill_ptr);
            alloc     = 1'b1;
            nxt_fill  = fill_ptr + PW'(1);
          end else begin
            n_spill = 1'b1;
          end
        end
      end
      S_ACT_RD: begin
        nxt_state = S_ACT_WR;
        n_write   = 1'b1;
        n_addr    = cam_addr;
        n_wdata   = inc;
        n_alert   = (inc >= ALERT_TH);
      end
      S_ACT_WR: nxt_state = S_IDLE;
      S_MAX: begin
        if (sub == 2'd3) nxt_state = S_MAX_WT;
        else nxt_sub = sub + 2'd1;
      end
      S_MAX_WT: begin
        if (cam_max == '0) begin
          nxt_state = S_IDLE;
          n_done    = 1'b1;
        end else begin
          nxt_state = S_SRCH;
          n_wdata   = cam_max;
        end
      end
      S_SRCH: begin
        if (match_ok) begin
          nxt_state = S_CLR;
          n_write   = 1'b1;
          n_addr    = cam_match_addr;
          n_row     = tag_row[msel];
          n_hit     = 1'b1;
          n_done    = 1'b1;
        end else begin
          // no entry holds the max: protocol error, finish without aggressor
          nxt_state = S_IDLE;
          n_done    = 1'b1;
        end
      end
      S_CLR: nxt_state = S_IDLE;
      default: nxt_state = S_INIT;
    endcase
    n_read   = (nxt_state == S_ACT_RD);
    n_max    = (nxt_state == S_MAX);
    n_search = (nxt_state == S_SRCH);
    n_ready  = (nxt_state == S_IDLE);
  end

  // state, tag table and registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= S_INIT;
      sub           <= 2'd0;
      fill_ptr      <= '0;
      tag_vld       <= '0;
      for (int i = 0; i < TRACK_NUM; i++) tag_row[i] <= '0;
      ready_q       <= 1'b0;
      rfm_done      <= 1'b0;
      rfm_hit       <= 1'b0;
      rfm_row       <= '0;
      alert         <= 1'b0;
      spill         <= 1'b0;
      cam_wdata     <= '0;
      cam_addr      <= '0;
      cam_read_en   <= 1'b0;
      cam_write_en  <= 1'b0;
      cam_search_en <= 1'b0;
      cam_reset     <= 1'b0;
      cam_max_en    <= 1'b0;
    end else begin
      state    <= nxt_state;
      sub      <= nxt_sub;
      fill_ptr <= nxt_fill;
      if (alloc) begin
        tag_row[fill_idx] <= act_row;
        tag_vld[fill_idx] <= 1'b1;
      end
      ready_q       <= n_ready;
      rfm_done      <= n_done;
      rfm_hit       <= n_hit;
      rfm_row       <= n_row;
      alert         <= n_alert;
      spill         <= n_spill;
      cam_wdata     <= n_wdata;
      cam_addr      <= n_addr;
      cam_read_en   <= n_read;
      cam_write_en  <= n_write;
      cam_search_en <= n_search;
      cam_reset     <= n_reset;
      cam_max_en    <= n_max;
    end
  end

endmodule

// File: doc/rfm_cnt_ctrl.md
Name: rfm_cnt_ctrl

Overview:
- Initiator/controller for the row-activation counter CAM in the RFM tracker.
- Keeps a row-tag table and maps each activated DRAM row to a CAM entry, then increments that entry's count with a CAM read-modify-write.
- On an RFM request, runs the CAM's 4-cycle find-max, searches the CAM for the entry holding the max value, clears that entry and reports its row as the aggressor.

Parameters:
- WORD_SIZE, 16, counter width; must match the CAM.
- ENTRY_WIDTH, 7, CAM address width.
- TRACK_NUM, 16, number of tracked entries (0..TRACK_NUM-1); the CAM max tree covers exactly these.
- ROW_BITS, 16, DRAM row address width.
- ALERT_TH, 16'd1024, count at or above which alert is raised.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- act_valid  in  1  activate command present
- act_row  in  ROW_BITS  activated row
- act_ready  out  1  controller can accept an ACT this cycle
- rfm_req  in  1  request aggressor selection (level, sampled in IDLE)
- rfm_done  out  1  1-cycle pulse, RFM sequence finished
- rfm_hit  out  1  valid with rfm_done: an aggressor was found (max>0)
- rfm_row  out  ROW_BITS  aggressor row, valid with rfm_done
- alert  out  1  1-cycle pulse: written count >= ALERT_TH
- spill  out  1  1-cycle pulse: ACT dropped, table full on miss
- cam_wdata  out  WORD_SIZE  CAM data_in (write data / search key)
- cam_addr  out  ENTRY_WIDTH  CAM addr_in
- cam_read_en, cam_write_en, cam_search_en, cam_reset, cam_max_en  out  1 each  CAM controls
- cam_rdata  in  WORD_SIZE  CAM data_out (combinational on read_en)
- cam_match  in  1  CAM match
- cam_match_addr  in  ENTRY_WIDTH  CAM lowest matching entry
- cam_max  in  WORD_SIZE  CAM max result

Behaviour:
- All outputs are registered. Reset values: all 0, except act_ready=0 during INIT. Tag valid bits are cleared; fill_ptr=0.
- States: INIT, IDLE, ACT_RD, ACT_WR, MAX (4 cycles, sub-count 0..3), MAX_WT, SRCH, CLR.
- INIT (first cycle after rstn release): cam_reset=1 for exactly 1 cycle, then IDLE. rstn mid-operation aborts to INIT. No partial CAM write is continued.
- IDLE:
  - act_ready=1 only in IDLE and only when rfm_req=0.
  - rfm_req has priority over act_valid when both are high: go to MAX, ACT not accepted.
  - Accepted ACT: compare act_row in parallel against all valid tags.
    - Hit: idx=hit index.
    - Miss with fill_ptr<TRACK_NUM: allocate idx=fill_ptr, write tag, set valid, fill_ptr+1. The CAM entry is already 0 after reset/clear.
    - Miss with table full: spill pulse, stay IDLE.
- ACT_RD (1 cycle): cam_read_en=1, cam_addr=idx; capture cam_rdata at clock edge.
- ACT_WR (1 cycle): cam_write_en=1, cam_wdata=count+1, saturating at all-ones. alert pulses the same cycle if the written value >= ALERT_TH. Return to IDLE.
- ACT throughput: one ACT per 3 cycles (IDLE, RD, WR).
- MAX:
  - cam_max_en=1 for exactly 4 consecutive cycles, then deasserted. Never a 5th cycle; a gap restarts CAM mode at 0.
  - MAX_WT (1 cycle): sample cam_max into mx.
  - If mx==0: rfm_done=1 and rfm_hit=0 next cycle, back to IDLE.
- SRCH (1 cycle): cam_search_en=1, cam_wdata=mx; capture cam_match and cam_match_addr.
  - If no match (protocol error): rfm_done=1, rfm_hit=0.
- CLR (1 cycle): cam_write_en=1, cam_addr=match addr, cam_wdata=0. Tag stays valid (row still tracked, count restarted). rfm_row=tag[match addr], rfm_hit=1, rfm_done=1. Back to IDLE.
- RFM latency: request in IDLE to rfm_done is 8 cycles (1 IDLE + 4 MAX + WT + SRCH + CLR).
- Ties among entries with equal max: the CAM's lowest matching index wins.
- At most one of cam_read_en/write_en/search_en/reset/max_en is high in any cycle. cam_addr/cam_wdata are 0 when unused.
- rfm_req held high after rfm_done starts a new sequence from IDLE.

Test Plan:
- Reset release -> cam_reset high exactly 1 cycle, act_ready=1 from the cycle after. Other outputs 0.
- ACT row 0x0A5 three times -> three RMWs on entry 0, written values 1,2,3, act_ready low 2 of every 3 cycles. ACT 0x1F0 -> allocated entry 1, written 1.
- Entries 0..3 at counts 3,7,7,2 (rows A,B,C,D) + rfm_req -> cam_max_en high 4 cycles, search key 7, entry 1 cleared. rfm_row=B, rfm_hit=1, rfm_done exactly 8 cycles after request.
- rfm_req and act_valid same cycle in IDLE -> RFM runs, ACT not accepted until rfm_done+1.
- 16 distinct rows fill the table, 17th new row -> spill pulse, no CAM write. ACT to an existing row still increments.
- Entry preloaded to ALERT_TH-1, one ACT -> write ALERT_TH, alert pulse same cycle as cam_write_en. rstn pulsed during MAX -> cam_max_en drops immediately, INIT re-clears the CAM.
